// File: rtl/reg_cmd_master_if.sv
// Command, response and register-access signals of reg_cmd_master.
// The master modport is the reg_cmd_master side; slave is the environment side.
interface reg_cmd_master_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 16
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_wr;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_wr;
   logic [ADDR_W-1:0] rsp_addr;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   logic              sel;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ready;

   modport master (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, rdata, ready,
      output cmd_ready, rsp_valid, rsp_wr, rsp_addr, rsp_rdata, rsp_err,
             sel, wr, addr, wdata
   );

   modport slave (
      output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, rdata, ready,
      input  cmd_ready, rsp_valid, rsp_wr, rsp_addr, rsp_rdata, rsp_err,
             sel, wr, addr, wdata
   );
endinterface

// File: rtl/reg_cmd_master.sv
// Register bus master: buffers read/write commands in a FIFO, issues them in
// order on sel/wr/addr/wdata, and returns one response per command.
module reg_cmd_master #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   reg_cmd_master_if.master             bus,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);
   localparam int unsigned CNT_W = $clog2(TIMEOUT);

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, REQ, RD_WAIT, RSP} state_t;

   state_t            state_q, state_d;
   cmd_t              cmd_q, cmd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              sel_q, sel_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_wr_q, rsp_wr_d;
   logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;

   cmd_t              mem_q [DEPTH];
   cmd_t              cmd_in;
   logic              push, pop;
   logic              rsp_load;
   logic              rsp_err_n;
   logic [DATA_W-1:0] rsp_rdata_n;

   assign cmd_in = '{wr: bus.cmd_wr, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
   assign push   = bus.cmd_valid & cmd_ready_q;

   // Sequencer: pop in IDLE, access phase in REQ, read-data phase in RD_WAIT
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      cnt_d       = cnt_q;
      pop         = 1'b0;
      rsp_load    = 1'b0;
      rsp_err_n   = 1'b0;
      rsp_rdata_n = '0;
      unique case (state_q)
         IDLE: begin
            if (level_q != '0) begin
               pop     = 1'b1;
               cmd_d   = mem_q[rd_ptr_q];
               cnt_d   = '0;
               state_d = REQ;
            end
         end
         REQ: begin
            if (bus.ready) begin
               if (cmd_q.wr) begin
                  rsp_load = 1'b1;
                  state_d  = RSP;
               end else begin
                  cnt_d   = '0;
                  state_d = RD_WAIT;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               rsp_load  = 1'b1;
               rsp_err_n = 1'b1;
               state_d   = RSP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RD_WAIT: begin
            if (bus.ready) begin
               rsp_load    = 1'b1;
               rsp_rdata_n = bus.rdata;
               state_d     = RSP;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               rsp_load  = 1'b1;
               rsp_err_n = 1'b1;
               state_d   = RSP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RSP: begin
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FIFO pointers/occupancy and registered outputs
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      level_d  = level_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
      cmd_ready_d = (level_d != LVL_W'(DEPTH));
      sel_d       = (state_d == REQ);
      rsp_valid_d = (state_d == RSP);
      rsp_wr_d    = rsp_load ? cmd_q.wr   : rsp_wr_q;
      rsp_addr_d  = rsp_load ? cmd_q.addr : rsp_addr_q;
      rsp_rdata_d = rsp_load ? rsp_rdata_n : rsp_rdata_q;
      rsp_err_d   = rsp_load ? rsp_err_n  : rsp_err_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cmd_q       <= '0;
         cnt_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         cmd_ready_q <= 1'b0;
         sel_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_wr_q    <= 1'b0;
         rsp_addr_q  <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         cnt_q       <= cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         cmd_ready_q <= cmd_ready_d;
         sel_q       <= sel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_wr_q    <= rsp_wr_d;
         rsp_addr_q  <= rsp_addr_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Storage needs no reset: entries are only read below the occupancy level
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= cmd_in;
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.sel       = sel_q;
   assign bus.wr        = cmd_q.wr;
   assign bus.addr      = cmd_q.addr;
   assign bus.wdata     = cmd_q.wdata;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_wr    = rsp_wr_q;
   assign bus.rsp_addr  = rsp_addr_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign fifo_level    = level_q;

endmodule
